// File: rtl/mem_llsc_bus_pkg.sv
// Shared definitions for the memory-stage bus unit: op encodings,
// control constants, FSM state type and the internal memory-op tag.
package mem_llsc_bus_pkg;

  localparam logic       RST_ENABLE   = 1'b0;
  localparam logic       WRITE_ENABLE = 1'b1;

  localparam logic [7:0] EXE_LW_OP = 8'b1110_0011;
  localparam logic [7:0] EXE_SW_OP = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP = 8'b1111_1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} bus_state_e;

  // Compact tag for the op held across the transaction.
  typedef enum logic [1:0] {MOP_LW, MOP_SW, MOP_LL, MOP_SC} mem_op_e;

  function automatic mem_op_e op_tag(input logic [7:0] aluop);
    case (aluop)
      EXE_SW_OP: op_tag = MOP_SW;
      EXE_LL_OP: op_tag = MOP_LL;
      EXE_SC_OP: op_tag = MOP_SC;
      default:   op_tag = MOP_LW;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Bus sequencer: state register, req/ack handshake, registered bus
// fields and captured read data for one word transaction at a time.
module mem_bus_fsm
  import mem_llsc_bus_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_wd,
  input  logic          i_wreg,
  input  logic          i_flush,
  input  logic          i_bus_ack,
  input  logic [DW-1:0] i_bus_rdata,
  output logic [1:0]    o_state,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [DW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  output logic [3:0]    o_bus_sel,
  output logic [1:0]    o_op,
  output logic [RW-1:0] o_wd,
  output logic          o_wreg,
  output logic [DW-1:0] o_rdata
);

  localparam logic [DW-1:0] WORD_MASK = {{(DW-2){1'b1}}, 2'b00};

  bus_state_e    state_q, state_d;
  mem_op_e       op_q, op_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [RW-1:0] wd_q, wd_d;
  logic          wreg_q, wreg_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Next state and field capture; fields are frozen once the request is up.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = BUSY;
          op_d    = mem_op_e'(i_op);
          addr_d  = i_addr & WORD_MASK;
          wdata_d = i_wdata;
          wd_d    = i_wd;
          wreg_d  = i_wreg;
        end
      end
      BUSY: begin
        if (i_bus_ack) begin
          rdata_d = i_bus_rdata;
          // A flush landing with the ack drops the result outright.
          state_d = i_flush ? IDLE : DONE;
        end else if (i_flush) begin
          state_d = ABORT;
        end
      end
      DONE:  state_d = IDLE;
      ABORT: if (i_bus_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and field registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n == RST_ENABLE) begin
      state_q <= IDLE;
      op_q    <= MOP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus drive: ABORT keeps the request up so an in-flight access completes.
  always_comb begin
    o_bus_req   = (state_q == BUSY) || (state_q == ABORT);
    o_bus_we    = o_bus_req && ((op_q == MOP_SW) || (op_q == MOP_SC));
    o_bus_addr  = o_bus_req ? addr_q  : '0;
    o_bus_wdata = o_bus_req ? wdata_q : '0;
    o_bus_sel   = o_bus_req ? 4'b1111 : 4'b0000;
  end

  assign o_state = state_q;
  assign o_op    = op_q;
  assign o_wd    = wd_q;
  assign o_wreg  = wreg_q;
  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_llsc_bus.sv
// Memory-stage data-bus access unit: word LW/SW plus LL/SC, stall
// generation, result muxing to MEM/WB and the LL-bit write.
module mem_llsc_bus
  import mem_llsc_bus_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_aluop,
  input  logic [RW-1:0] i_wd,
  input  logic          i_wreg,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_reg2,
  input  logic          i_flush,
  input  logic          i_llbit,
  input  logic          i_wb_llbit_wen,
  input  logic          i_wb_llbit,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [DW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  output logic [3:0]    o_bus_sel,
  input  logic          i_bus_ack,
  input  logic [DW-1:0] i_bus_rdata,
  output logic [RW-1:0] o_wd,
  output logic          o_wreg,
  output logic [DW-1:0] o_wdata,
  output logic          o_llbit_wen,
  output logic          o_llbit,
  output logic          o_stallreq
);

  logic          is_mem, is_sc, eff_llbit, sc_fail, start;
  logic [1:0]    fsm_state;
  logic [1:0]    fsm_op;
  logic [RW-1:0] fsm_wd;
  logic          fsm_wreg;
  logic [DW-1:0] fsm_rdata;
  bus_state_e    state;
  mem_op_e       op_r;

  // Op decode and SC resolution; a same-cycle writeback LL-bit write wins.
  always_comb begin
    is_mem    = (i_aluop == EXE_LW_OP) || (i_aluop == EXE_SW_OP) ||
                (i_aluop == EXE_LL_OP) || (i_aluop == EXE_SC_OP);
    is_sc     = (i_aluop == EXE_SC_OP);
    eff_llbit = i_wb_llbit_wen ? i_wb_llbit : i_llbit;
    sc_fail   = is_sc && !eff_llbit;
    start     = is_mem && !sc_fail && !i_flush;
  end

  mem_bus_fsm #(.DW(DW), .RW(RW)) u_fsm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (start),
    .i_op        (op_tag(i_aluop)),
    .i_addr      (i_mem_addr),
    .i_wdata     (i_reg2),
    .i_wd        (i_wd),
    .i_wreg      (i_wreg),
    .i_flush     (i_flush),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata),
    .o_state     (fsm_state),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_sel   (o_bus_sel),
    .o_op        (fsm_op),
    .o_wd        (fsm_wd),
    .o_wreg      (fsm_wreg),
    .o_rdata     (fsm_rdata)
  );

  assign state = bus_state_e'(fsm_state);
  assign op_r  = mem_op_e'(fsm_op);

  // Result mux to MEM/WB, LL-bit write and stall request.
  always_comb begin
    o_wd        = i_wd;
    o_wreg      = i_wreg;
    o_wdata     = i_wdata;
    o_llbit_wen = 1'b0;
    o_llbit     = 1'b0;
    o_stallreq  = 1'b0;
    case (state)
      IDLE: begin
        if (i_flush) begin
          o_wreg = 1'b0;
        end else if (sc_fail) begin
          // Failed SC writes 0 to rt without touching the bus.
          o_wdata = '0;
        end else if (is_mem) begin
          o_wreg     = 1'b0;
          o_stallreq = 1'b1;
        end
      end
      BUSY, ABORT: begin
        o_wreg     = 1'b0;
        o_stallreq = 1'b1;
      end
      DONE: begin
        o_wd   = fsm_wd;
        o_wreg = fsm_wreg && !i_flush;
        case (op_r)
          MOP_SW:  o_wdata = '0;
          MOP_SC:  o_wdata = {{(DW-1){1'b0}}, 1'b1};
          default: o_wdata = fsm_rdata;
        endcase
        o_llbit_wen = ((op_r == MOP_LL) || (op_r == MOP_SC)) && !i_flush;
        o_llbit     = (op_r == MOP_LL) && !i_flush;
      end
      default: begin
        o_wreg = 1'b0;
      end
    endcase
  end

endmodule
